// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered, handshaked LEGv8 instruction decoder placed between fetch and
// register read. Each accepted instruction is classified into a format
// (R/I/D/B/CB/IW or illegal). The stage extracts the register numbers and
// produces a sign- or zero-extended immediate. A main output register plus
// one skid register keep in_ready registered, so in_ready has no
// combinational path from out_ready.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 drop every held entry and any instruction offered now
//   in_valid / in_ready   upstream handshake (in_ready is a flop output)
//   instruction           raw instruction word
//   out_valid / out_ready downstream handshake
//   opcode, fmt           instruction[31:21], format code (7 = illegal)
//   rd_num, rn_num,       register fields [4:0], [9:5], [20:16]
//   rm_num
//   shamt, hw             R-format shift amount, IW half-word select (else 0)
//   imm                   extended immediate (not scaled)
//   illegal_cnt           saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int INSTR_LEN = 32,
    parameter int DATA_LEN  = 64,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_LEN-1:0] instruction,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [10:0]          opcode,
    output logic [2:0]           fmt,
    output logic [4:0]           rd_num,
    output logic [4:0]           rn_num,
    output logic [4:0]           rm_num,
    output logic [5:0]           shamt,
    output logic [1:0]           hw,
    output logic [DATA_LEN-1:0]  imm,
    output logic [CNT_W-1:0]     illegal_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_D   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_CB  = 3'd4;
    localparam logic [2:0] FMT_IW  = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [10:0]         opcode;
        logic [2:0]          fmt;
        logic [4:0]          rd;
        logic [4:0]          rn;
        logic [4:0]          rm;
        logic [5:0]          shamt;
        logic [1:0]          hw;
        logic [DATA_LEN-1:0] imm;
    } dec_t;

    dec_t             dec_in;
    dec_t             main_q, main_d;
    dec_t             skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      op;
    logic             accept;

    // -------------------------------------------------------------------------
    // Combinational decode of the word currently offered on the input.
    // -------------------------------------------------------------------------
    assign op = instruction[31:21];

    always_comb begin
        // NOTE: every field gets a default before the priority chain; a path
        // that leaves a combinational variable unassigned would infer a latch.
        dec_in        = '0;
        dec_in.opcode = op;
        dec_in.rd     = instruction[4:0];
        dec_in.rn     = instruction[9:5];
        dec_in.rm     = instruction[20:16];
        dec_in.fmt    = FMT_ILL;

        if (op inside {11'h458, 11'h658, 11'h450, 11'h550, 11'h69B, 11'h69A}) begin
            dec_in.fmt   = FMT_R;
            dec_in.shamt = instruction[15:10];
        end else if (op[10:1] inside {10'h244, 10'h344}) begin
            dec_in.fmt = FMT_I;
            dec_in.imm = {{(DATA_LEN-12){1'b0}}, instruction[21:10]};
        end else if (op inside {11'h7C2, 11'h7C0}) begin
            dec_in.fmt = FMT_D;
            dec_in.imm = {{(DATA_LEN-9){instruction[20]}}, instruction[20:12]};
        end else if (op[10:5] == 6'h05) begin
            dec_in.fmt = FMT_B;
            dec_in.imm = {{(DATA_LEN-26){instruction[25]}}, instruction[25:0]};
        end else if (op[10:3] inside {8'hB4, 8'hB5}) begin
            dec_in.fmt = FMT_CB;
            dec_in.imm = {{(DATA_LEN-19){instruction[23]}}, instruction[23:5]};
        end else if (op[10:2] == 9'h1A5) begin
            dec_in.fmt = FMT_IW;
            dec_in.hw  = instruction[22:21];
            dec_in.imm = {{(DATA_LEN-16){1'b0}}, instruction[20:5]};
        end
    end

    // -------------------------------------------------------------------------
    // Handshake and skid control.
    // -------------------------------------------------------------------------
    // Flush takes priority over accept: an instruction offered during a flush
    // is neither stored nor counted.
    assign accept = in_valid && in_ready_q && !flush;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_valid_q && !out_ready) begin
            // Main is stalled and must not change; park the newcomer in skid.
            // Accept is only possible here when skid is empty.
            if (accept) begin
                skid_d       = dec_in;
                skid_valid_d = 1'b1;
            end
        end else if (skid_valid_q) begin
            // Main is empty or draining: the older skid entry goes first.
            // in_ready is low while skid is full, so nothing arrives now.
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            main_d       = dec_in;
            main_valid_d = 1'b1;
        end else begin
            main_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && (dec_in.fmt == FMT_ILL) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data registers are reset as well as the valid flags,
            // because the decoded fields are visible on the outputs and must
            // read as zero after reset.
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            // Registered copy of "skid will be empty next cycle".
            in_ready_q   <= ~skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from the main register, so they hold while stalled.
    // -------------------------------------------------------------------------
    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign opcode      = main_q.opcode;
    assign fmt         = main_q.fmt;
    assign rd_num      = main_q.rd;
    assign rn_num      = main_q.rn;
    assign rm_num      = main_q.rm;
    assign shamt       = main_q.shamt;
    assign hw          = main_q.hw;
    assign imm         = main_q.imm;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Scoreboard bench for decode_stage. Stimulus pushes a hand-computed expected
// entry when an instruction is accepted; an independent monitor pops and
// compares whenever the DUT emits. A second instance with CNT_W=2 shares the
// stimulus to exercise illegal_cnt saturation.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    typedef struct {
        logic [31:0] word;
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [5:0]  shamt;
        logic [1:0]  hw;
        logic [63:0] imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] instruction = '0;

    logic        in_ready, out_valid;
    logic [10:0] opcode;
    logic [2:0]  fmt;
    logic [4:0]  rd_num, rn_num, rm_num;
    logic [5:0]  shamt;
    logic [1:0]  hw;
    logic [63:0] imm;
    logic [15:0] illegal_cnt;

    logic        in_ready2, out_valid2;
    logic [10:0] opcode2;
    logic [2:0]  fmt2;
    logic [4:0]  rd2, rn2, rm2;
    logic [5:0]  shamt2;
    logic [1:0]  hw2;
    logic [63:0] imm2;
    logic [1:0]  illegal_cnt2;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .fmt(fmt), .rd_num(rd_num), .rn_num(rn_num),
        .rm_num(rm_num), .shamt(shamt), .hw(hw), .imm(imm),
        .illegal_cnt(illegal_cnt)
    );

    decode_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .instruction(instruction),
        .out_valid(out_valid2), .out_ready(out_ready),
        .opcode(opcode2), .fmt(fmt2), .rd_num(rd2), .rn_num(rn2),
        .rm_num(rm2), .shamt(shamt2), .hw(hw2), .imm(imm2),
        .illegal_cnt(illegal_cnt2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] word, input logic [2:0] f,
                                input logic [4:0] rd, input logic [4:0] rn,
                                input logic [4:0] rm, input logic [5:0] sh,
                                input logic [1:0] h, input logic [63:0] im);
        exp_t e;
        e.word = word; e.fmt = f; e.rd = rd; e.rn = rn; e.rm = rm;
        e.shamt = sh; e.hw = h; e.imm = im;
        return e;
    endfunction

    // Hand-decoded vectors.
    exp_t e_add, e_ldur, e_b, e_cbz, e_addi, e_movz, e_lsl, e_stur, e_ill;
    initial begin
        e_add  = mk(32'h8B020023, 3'd0, 5'd3,  5'd1,  5'd2,  6'd0, 2'd0, 64'h0);
        e_ldur = mk(32'hF85F80E5, 3'd2, 5'd5,  5'd7,  5'd31, 6'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FFF8);
        e_b    = mk(32'h17FFFFFF, 3'd3, 5'd31, 5'd31, 5'd31, 6'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        e_cbz  = mk(32'hB4000089, 3'd4, 5'd9,  5'd4,  5'd0,  6'd0, 2'd0, 64'h4);
        e_addi = mk(32'h913FFC41, 3'd1, 5'd1,  5'd2,  5'd31, 6'd0, 2'd0, 64'hFFF);
        e_movz = mk(32'hD2D00027, 3'd5, 5'd7,  5'd1,  5'd16, 6'd0, 2'd2, 64'h8001);
        e_lsl  = mk(32'hD3601464, 3'd0, 5'd4,  5'd3,  5'd0,  6'd5, 2'd0, 64'h0);
        e_stur = mk(32'hF8010041, 3'd2, 5'd1,  5'd2,  5'd1,  6'd0, 2'd0, 64'h10);
        e_ill  = mk(32'h00000000, 3'd7, 5'd0,  5'd0,  5'd0,  6'd0, 2'd0, 64'h0);
    end

    // Monitor: compare every emitted entry against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("opcode", 64'(opcode), 64'(e.word[31:21]));
                    check("fmt",    64'(fmt),    64'(e.fmt));
                    check("rd",     64'(rd_num), 64'(e.rd));
                    check("rn",     64'(rn_num), 64'(e.rn));
                    check("rm",     64'(rm_num), 64'(e.rm));
                    check("shamt",  64'(shamt),  64'(e.shamt));
                    check("hw",     64'(hw),     64'(e.hw));
                    check("imm",    imm,         e.imm);
                end
            end
        end
    end

    // Offer one instruction; returns #1 after the accepting edge.
    task automatic send(input exp_t e);
        int n;
        n = 0;
        in_valid    = 1'b1;
        instruction = e.word;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // Reset state.
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid),   64'd0);
        check("rst_in_ready",  64'(in_ready),    64'd1);
        check("rst_cnt",       64'(illegal_cnt), 64'd0);
        check("rst_fmt",       64'(fmt),         64'd0);
        check("rst_imm",       imm,              64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Illegal counting and saturation of the narrow counter.
        repeat (3) send(e_ill);
        drain();
        check("ill_cnt3",   64'(illegal_cnt),  64'd3);
        check("ill_cnt3_w2", 64'(illegal_cnt2), 64'd3);
        repeat (2) send(e_ill);
        drain();
        check("ill_cnt5",    64'(illegal_cnt),  64'd5);
        check("ill_sat_w2",  64'(illegal_cnt2), 64'd3);

        // Back-to-back stream with out_ready held high.
        send(e_add);
        send(e_ldur);
        send(e_b);
        send(e_cbz);
        send(e_addi);
        send(e_movz);
        send(e_lsl);
        send(e_stur);
        drain();

        // Backpressure: three offered, two held, third waits.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = e_add.word;
        @(posedge clk); sb.push_back(e_add);
        #1 instruction = e_lsl.word;
        @(posedge clk); sb.push_back(e_lsl);
        #1 instruction = e_movz.word;
        @(negedge clk);
        check("bp_in_ready0", 64'(in_ready),  64'd0);
        check("bp_valid",     64'(out_valid), 64'd1);
        check("bp_opcode",    64'(opcode),    64'h458);
        check("bp_rd",        64'(rd_num),    64'd3);
        @(negedge clk);
        check("bp_in_ready0b", 64'(in_ready), 64'd0);
        check("bp_opcode_hold", 64'(opcode),  64'h458);
        check("bp_rm_hold",   64'(rm_num),    64'd2);
        @(posedge clk);
        #1 out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        check("bp_ready_latency", 64'(n), 64'd2);
        @(posedge clk); sb.push_back(e_movz);
        #1 in_valid = 1'b0;
        drain();

        // Flush with two entries held and an illegal word offered.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = e_stur.word;
        @(posedge clk); sb.push_back(e_stur);
        #1 instruction = e_addi.word;
        @(posedge clk); sb.push_back(e_addi);
        #1 instruction = e_ill.word;
        flush = 1'b1;
        @(negedge clk);
        check("fl_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("fl_out_valid", 64'(out_valid),   64'd0);
        check("fl_in_ready",  64'(in_ready),    64'd1);
        check("fl_cnt",       64'(illegal_cnt), 64'd5);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("fl_quiet", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset with both registers full.
        out_ready = 1'b0;
        send(e_b);
        send(e_cbz);
        @(negedge clk);
        check("mr_full",  64'(in_ready),  64'd0);
        check("mr_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mr_out_valid", 64'(out_valid),   64'd0);
        check("mr_in_ready",  64'(in_ready),    64'd1);
        check("mr_cnt",       64'(illegal_cnt), 64'd0);
        check("mr_opcode",    64'(opcode),      64'd0);
        check("mr_imm",       imm,              64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;

        // Recovery after reset.
        send(e_add);
        send(e_ldur);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked LEGv8 instruction decoder sitting between fetch and register read.
- Accepts one instruction per cycle over a valid/ready handshake.
- Classifies format (R/I/D/B/CB/IW), extracts register numbers and emits a sign- or zero-extended immediate.
- A 2-entry skid buffer keeps in_ready registered, free of any combinational path from out_ready. Flush support is included for branch redirect.

Parameters:
- INSTR_LEN, 32, instruction width; only 32 is supported.
- DATA_LEN, 64, width of the extended immediate output.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discard all held and incoming instructions this cycle.
- in_valid  input  1  instruction presented.
- in_ready  output  1  stage can accept; registered.
- instruction  input  INSTR_LEN  raw instruction word.
- out_valid  output  1  decoded entry available.
- out_ready  input  1  downstream accepts.
- opcode  output  11  instruction[31:21].
- fmt  output  3  0=R, 1=I, 2=D, 3=B, 4=CB, 5=IW, 7=illegal.
- rd_num  output  5  instruction[4:0] (Rd, or Rt for D/CB).
- rn_num  output  5  instruction[9:5].
- rm_num  output  5  instruction[20:16].
- shamt  output  6  instruction[15:10]; R-format only, else 0.
- hw  output  2  instruction[22:21]; IW only, else 0.
- imm  output  DATA_LEN  extended immediate.
- illegal_cnt  output  CNT_W  count of illegal instructions accepted.

Behaviour:
- Classification (combinational on input), checked in priority order R, I, D, B, CB, IW:
  - R: opcode in {0x458 ADD, 0x658 SUB, 0x450 AND, 0x550 ORR, 0x69B LSL, 0x69A LSR}.
  - I: opcode[10:1] in {0x244 ADDI, 0x344 SUBI}.
  - D: opcode in {0x7C2 LDUR, 0x7C0 STUR}.
  - B: opcode[10:5]==0x05.
  - CB: opcode[10:3] in {0xB4 CBZ, 0xB5 CBNZ}.
  - IW: opcode[10:2]==0x1A5 (MOVZ).
  - Anything else: fmt=7.
- Immediate by format:
  - I: zero-extend instr[21:10].
  - D: sign-extend instr[20:12].
  - B: sign-extend instr[25:0].
  - CB: sign-extend instr[23:5].
  - IW: zero-extend instr[20:5].
  - R and illegal: 0.
  - No scaling; the consumer shifts branch offsets.
- Pipeline:
  - Latency 1: an instruction accepted at edge N is visible on the outputs after edge N.
  - Main output register plus one skid register. in_ready = ~skid_valid.
  - Accept when in_valid && in_ready.
  - If out_valid && !out_ready at the accept edge, the new entry goes to the skid register. Otherwise it goes to the main register.
  - On out_valid && out_ready, the main register loads from the skid register if it is valid, else from the accepted input, else out_valid drops.
  - Order is strictly preserved. Throughput is 1/cycle while out_ready stays high.
- Output stability: all outputs hold constant while out_valid && !out_ready.
- Flush:
  - At the edge, flush clears main and skid valid.
  - An instruction offered in the same cycle is dropped; flush wins over accept.
  - in_ready is 1 the following cycle.
  - illegal_cnt does not count dropped instructions.
- illegal_cnt:
  - Increments once when an instruction with fmt=7 is accepted (not when it is emitted).
  - Saturates at all-ones.
  - Unaffected by flush.
- Reset (asynchronous, immediate):
  - out_valid=0, skid empty, in_ready=1, illegal_cnt=0.
  - opcode, fmt, register numbers, shamt, hw and imm = 0.
  - Reset mid-stream discards all held entries.

Test Plan:
- Stream, out_ready=1: ADD 0x8B020023 then LDUR 0xF85F80E5.
  - Cycle 1: fmt=0, rd=3, rn=1, rm=2, imm=0.
  - Cycle 2: fmt=2, rd=5, rn=7, imm=0xFFFFFFFFFFFFFFF8.
- Sign extension: B 0x17FFFFFF gives fmt=3, imm=all ones. CBZ 0xB4000089 gives fmt=4, rd=9, imm=4.
- Backpressure:
  - Setup: hold out_ready=0, offer 3 back-to-back instructions.
  - Expected: 2 accepted, in_ready=0 on the third cycle, outputs stable.
  - Then raise out_ready: both emitted in order on consecutive cycles, then the third is accepted.
- Flush:
  - Setup: two entries held; assert flush with in_valid=1.
  - Expected: next cycle out_valid=0 and in_ready=1, the offered word is never emitted.
- Illegal:
  - Accept 0x00000000 three times: fmt=7 each time, illegal_cnt=3.
  - With CNT_W=2, after 5 illegal instructions illegal_cnt=3.
- Reset mid-operation:
  - Setup: assert rst asynchronously with both entries full.
  - Expected: out_valid=0 immediately, in_ready=1, illegal_cnt=0.
